mac_lane_accumulator: RTL and testbench

//  Downstream of the 8x8 multi-precision multiplier: consumes its per-beat packed signed partial

---
 rtl/mac_pkg.sv | 37 +++
 rtl/mac_acc_lane.sv | 44 ++++
 rtl/mac_lane_accumulator.sv | 136 +++++++++++++
 tb/tb_mac_lane_accumulator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the 8x8 multi-precision multiplier and its lane accumulator:
// precision-mode codes, convolution-type codes, lane counts and the mode -> active-lane mask map.
package mac_pkg;

    localparam logic [2:0] M8X8 = 3'd0;
    localparam logic [2:0] M8X4 = 3'd1;
    localparam logic [2:0] M8X2 = 3'd2;
    localparam logic [2:0] M4X4 = 3'd3;
    localparam logic [2:0] M4X2 = 3'd4;
    localparam logic [2:0] M2X2 = 3'd5;

    localparam logic [1:0] CONV_STD = 2'd0;
    localparam logic [1:0] CONV_DW  = 2'd1;
    localparam logic [1:0] CONV_PW  = 2'd2;

    localparam int N_LANES = 4;
    localparam int LANES_1 = 1;
    localparam int LANES_2 = 2;
    localparam int LANES_4 = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } acc_state_t;

    // Narrower operands pack more products per beat; reserved codes fall back to one lane.
    function automatic logic [3:0] lane_mask(input logic [2:0] mode);
        case (mode)
            M8X8:             lane_mask = 4'b0001;
            M8X4, M4X4:       lane_mask = 4'b0011;
            M8X2, M4X2, M2X2: lane_mask = 4'b1111;
            default:          lane_mask = 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/mac_acc_lane.sv
// One accumulator lane: clear/enable/add of a sign-extended product, plus output narrowing.
// Build option MAC_ACC_SAT_EN: clamp the narrowed result instead of wrapping it.
module mac_acc_lane #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 32,
    parameter int OUT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [IN_W-1:0]  i_prod,
    output logic [OUT_W-1:0] o_res,
    output logic             o_ovf
);

    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     w_sum;
    logic [ACC_W-1:0]     w_next;
    logic [ACC_W-OUT_W:0] w_top;

    assign w_sum  = r_acc + {{(ACC_W-IN_W){i_prod[IN_W-1]}}, i_prod};
    assign w_next = i_en ? w_sum : r_acc;

    // The value fits OUT_W signed bits only if every bit from OUT_W-1 upward equals the sign.
    assign w_top = w_next[ACC_W-1:OUT_W-1];
    assign o_ovf = !((&w_top) || !(|w_top));

`ifdef MAC_ACC_SAT_EN
    assign o_res = o_ovf ? {w_next[ACC_W-1], {(OUT_W-1){~w_next[ACC_W-1]}}}
                         : w_next[OUT_W-1:0];
`else
    assign o_res = w_next[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/mac_lane_accumulator.sv
// Kernel accumulator for packed multiplier products: FSM, beat counter, config latches, handshakes.
// Build option MAC_ACC_SAT_EN (in mac_acc_lane) selects saturating instead of wrapping outputs.
module mac_lane_accumulator
    import mac_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int ACC_W = 32,
    parameter int OUT_W = 24,
    parameter int KMAX  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 cfg_mode,
    input  logic [$clog2(KMAX+1)-1:0]  cfg_klen,
    input  logic                       start,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4*IN_W-1:0]          in_prod,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4*OUT_W-1:0]         out_data,
    output logic [3:0]                 out_lanes,
    output logic                       out_ovf,
    output logic [1:0]                 o_dbg_state
);

    localparam int KLEN_W = $clog2(KMAX+1);

    // Handshakes: a transfer happens on a rising edge where valid && ready. in_ready is high only
    // in ACCUM; out_valid is high only in OUTPUT and out_data/out_lanes/out_ovf hold until taken.

    acc_state_t          r_state;
    acc_state_t          w_state_nxt;
    logic [3:0]          r_mask;
    logic [KLEN_W-1:0]   r_klen;
    logic [KLEN_W-1:0]   r_count;
    logic [4*OUT_W-1:0]  r_out_data;
    logic [3:0]          r_out_lanes;
    logic                r_out_ovf;

    logic                w_start_acc;
    logic                w_beat;
    logic                w_last;
    logic [OUT_W-1:0]    w_lane_res [4];
    logic [3:0]          w_lane_ovf;
    logic [4*OUT_W-1:0]  w_out_nxt;
    logic                w_ovf_any;

    assign w_start_acc = start && (r_state == S_IDLE);
    assign w_beat      = in_valid && in_ready;
    assign w_last      = w_beat && (r_count == (r_klen - KLEN_W'(1)));

    for (genvar g = 0; g < 4; g++) begin : g_lane
        mac_acc_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_clear (w_start_acc),
            .i_en    (w_beat && r_mask[g]),
            .i_prod  (in_prod[g*IN_W +: IN_W]),
            .o_res   (w_lane_res[g]),
            .o_ovf   (w_lane_ovf[g])
        );
    end

    always_comb begin
        w_out_nxt = '0;
        w_ovf_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_mask[i]) begin
                w_out_nxt[i*OUT_W +: OUT_W] = w_lane_res[i];
                w_ovf_any = w_ovf_any | w_lane_ovf[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && (r_count == (r_klen - KLEN_W'(1)))) w_state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_klen      <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_lanes <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_mask  <= lane_mask(cfg_mode);
                r_klen  <= (cfg_klen == '0) ? KLEN_W'(1) : cfg_klen;
                r_count <= '0;
            end else if (w_beat) begin
                r_count <= r_count + KLEN_W'(1);
            end
            // Capture from the sums including the last beat, so the result is valid next cycle.
            if (w_last) begin
                r_out_data  <= w_out_nxt;
                r_out_lanes <= r_mask;
                r_out_ovf   <= w_ovf_any;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_lanes   = r_out_lanes;
    assign out_ovf     = r_out_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_lane_accumulator.sv
// Directed-vector bench for mac_lane_accumulator with hand-computed expected results.
module tb_mac_lane_accumulator;
    import mac_pkg::*;

    logic         clk;
    logic         rst;
    logic [2:0]   cfg_mode;
    logic [10:0]  cfg_klen;
    logic         start;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_prod;
    logic         out_valid;
    logic         out_ready;
    logic [95:0]  out_data;
    logic [3:0]   out_lanes;
    logic         out_ovf;
    logic [1:0]   o_dbg_state;

    int n_err = 0;
    int n_chk = 0;
    logic [95:0] exp_q[$];

    mac_lane_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_mode    (cfg_mode),
        .cfg_klen    (cfg_klen),
        .start       (start),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_prod     (in_prod),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_lanes   (out_lanes),
        .out_ovf     (out_ovf),
        .o_dbg_state (o_dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_in(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    function automatic logic [95:0] pack_out(input int l0, input int l1, input int l2, input int l3);
        return {24'(l3), 24'(l2), 24'(l1), 24'(l0)};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_kernel(input logic [2:0] mode, input int klen);
        cfg_mode = mode;
        cfg_klen = 11'(klen);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] p);
        in_valid = 1'b1;
        in_prod  = p;
        tick();
        in_valid = 1'b0;
        in_prod  = 64'hdead_beef_cafe_f00d;
    endtask

    task automatic take_result(input string tag, input logic [95:0] exp_data,
                               input logic [3:0] exp_lanes, input logic exp_ovf);
        int waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_lanes"}, out_lanes, exp_lanes);
        check({tag, "_ovf"}, out_ovf, exp_ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_busy_drop"}, busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_mode  = '0;
        cfg_klen  = '0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 96'd0);
        check("rst_out_lanes", out_lanes, 4'd0);
        check("rst_out_ovf", out_ovf, 1'b0);
        check("rst_state", o_dbg_state, S_IDLE);
        rst = 1'b0;
        tick();

        // 8x8, klen 3, garbage in lanes 1-3; cfg changed after start must not matter
        start_kernel(M8X8, 3);
        cfg_mode = M2X2;
        cfg_klen = 11'd7;
        check("t1_busy", busy, 1'b1);
        check("t1_in_ready", in_ready, 1'b1);
        check("t1_state", o_dbg_state, S_ACCUM);
        send_beat(pack_in(100, 1234, -5, 77));
        send_beat(pack_in(-50, -999, 3, 3));
        check("t1_no_early_valid", out_valid, 1'b0);
        send_beat(pack_in(7, 11, 22, 33));
        check("t1_latency", out_valid, 1'b1);
        take_result("t1", pack_out(57, 0, 0, 0), 4'b0001, 1'b0);

        // 4x2, klen 2, sums cancel in every lane
        start_kernel(M4X2, 2);
        send_beat(pack_in(1, 2, 3, 4));
        check("t2_no_early_valid", out_valid, 1'b0);
        send_beat(pack_in(-1, -2, -3, -4));
        check("t2_latency", out_valid, 1'b1);
        check("t2_in_ready_low", in_ready, 1'b0);

        // backpressure: result held while start/in_valid are driven and ignored
        start    = 1'b1;
        in_valid = 1'b1;
        in_prod  = pack_in(500, 500, 500, 500);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", out_valid, 1'b1);
            check("t3_hold_data", out_data, 96'd0);
            check("t3_hold_lanes", out_lanes, 4'b1111);
            check("t3_in_ready", in_ready, 1'b0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        take_result("t2", 96'd0, 4'b1111, 1'b0);
        start_kernel(M4X2, 1);
        send_beat(pack_in(1, 1, 1, 1));
        take_result("t3_after", pack_out(1, 1, 1, 1), 4'b1111, 1'b0);

        // overflow: 600 x 32767 = 19660200 = 0x12BFDA8
        start_kernel(M8X8, 600);
        for (int i = 0; i < 600; i++) send_beat(pack_in(32767, 5, 5, 5));
`ifdef MAC_ACC_SAT_EN
        take_result("t4", pack_out(8388607, 0, 0, 0), 4'b0001, 1'b1);
`else
        take_result("t4", pack_out(2882984, 0, 0, 0), 4'b0001, 1'b1);
`endif

        // reset mid-kernel
        start_kernel(M2X2, 4);
        send_beat(pack_in(1, 2, 3, 4));
        send_beat(pack_in(1, 2, 3, 4));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_in_ready", in_ready, 1'b0);
        check("t5_out_data", out_data, 96'd0);
        check("t5_out_lanes", out_lanes, 4'd0);
        check("t5_out_ovf", out_ovf, 1'b0);
        start_kernel(M8X8, 1);
        send_beat(pack_in(9, 0, 0, 0));
        take_result("t5_new", pack_out(9, 0, 0, 0), 4'b0001, 1'b0);

        // klen 0 behaves as 1
        start_kernel(M4X4, 0);
        send_beat(pack_in(5, -6, 100, 100));
        check("t6_klen0_latency", out_valid, 1'b1);
        take_result("t6_klen0", pack_out(5, -6, 0, 0), 4'b0011, 1'b0);

        // back-to-back kernels with input gaps
        exp_q.push_back(pack_out(-1293, -15, 0, 0));
        exp_q.push_back(pack_out(65534, -65536, 0, 0));
        start_kernel(M8X4, 3);
        send_beat(pack_in(-300, 20, 9, 9));
        tick();
        send_beat(pack_in(-1000, 5, 9, 9));
        tick();
        tick();
        check("t6a_no_early_valid", out_valid, 1'b0);
        send_beat(pack_in(7, -40, 9, 9));
        take_result("t6a", exp_q.pop_front(), 4'b0011, 1'b0);
        start_kernel(M8X2, 2);
        tick();
        send_beat(pack_in(32767, -32768, 1, 0));
        tick();
        send_beat(pack_in(32767, -32768, -1, 0));
        take_result("t6b", exp_q.pop_front(), 4'b1111, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
